// File: rtl/edge_stream.sv
// ============================================================================
// Module      : edge_stream
// Description : Grid-edge I/O endpoint for one node direction port. The host
//               pushes words into an inbound FIFO that is offered to the node
//               over a req/ack handshake. Words written by the node land in an
//               outbound FIFO that the host pops (show-ahead head).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_stream #(
  parameter int WORD_W = 11,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  // host side, inbound FIFO
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  output logic              full,
  // host side, outbound FIFO
  input  logic              pop,
  output logic [WORD_W-1:0] pop_data,
  output logic              empty,
  output logic              ovf,
  // edge -> node
  output logic              to_node_req,
  output logic [WORD_W-1:0] to_node_data,
  input  logic              to_node_ack,
  // node -> edge
  input  logic              fr_node_req,
  input  logic [WORD_W-1:0] fr_node_data,
  output logic              fr_node_ack
);

  // Pointer width carries one extra bit so full and empty are distinguishable.
  localparam int            c_AW        = $clog2(DEPTH);
  localparam logic [c_AW:0] c_DEPTH_CNT = (c_AW + 1)'(DEPTH);

  localparam logic [0:0] c_TX_IDLE  = 1'b0;
  localparam logic [0:0] c_TX_OFFER = 1'b1;
  localparam logic [0:0] c_RX_IDLE  = 1'b0;
  localparam logic [0:0] c_RX_ACK   = 1'b1;

  // --------------------------------------------------------------------------
  // Inbound FIFO (host -> node)
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] r_in_mem [DEPTH];
  logic [c_AW:0]     r_in_wr;
  logic [c_AW:0]     r_in_rd;
  logic [c_AW:0]     w_in_count;
  logic              w_in_full;
  logic              w_in_empty;
  logic              w_in_pop;
  logic              w_in_push_ok;
  logic              w_in_drop;
  logic [WORD_W-1:0] w_in_head;

  logic [0:0]        r_tx_state;
  logic              r_to_node_req;
  logic [WORD_W-1:0] r_to_node_data;

  assign w_in_count   = r_in_wr - r_in_rd;
  assign w_in_full    = (w_in_count == c_DEPTH_CNT);
  assign w_in_empty   = (r_in_wr == r_in_rd);
  // The offered word leaves the FIFO only once the node has taken it.
  assign w_in_pop     = (r_tx_state == c_TX_OFFER) && to_node_ack;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign w_in_push_ok = push && (!w_in_full || w_in_pop);
  assign w_in_drop    = push && w_in_full && !w_in_pop;
  assign w_in_head    = r_in_mem[r_in_rd[c_AW-1:0]];

  // Inbound storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (w_in_push_ok) begin
      r_in_mem[r_in_wr[c_AW-1:0]] <= push_data;
    end
  end

  // Inbound pointer update; both pointers may move in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_wr <= '0;
      r_in_rd <= '0;
    end else if (clear) begin
      r_in_wr <= '0;
      r_in_rd <= '0;
    end else begin
      if (w_in_push_ok) begin
        r_in_wr <= r_in_wr + 1'b1;
      end
      if (w_in_pop) begin
        r_in_rd <= r_in_rd + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX handshake: offer the inbound head and hold it until the node acks.
  // --------------------------------------------------------------------------
  // TX FSM; data is captured on entry to OFFER so later pushes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state     <= c_TX_IDLE;
      r_to_node_req  <= 1'b0;
      r_to_node_data <= '0;
    end else if (clear) begin
      r_tx_state     <= c_TX_IDLE;
      r_to_node_req  <= 1'b0;
      r_to_node_data <= '0;
    end else if (r_tx_state == c_TX_IDLE) begin
      if (!w_in_empty) begin
        r_tx_state     <= c_TX_OFFER;
        r_to_node_req  <= 1'b1;
        r_to_node_data <= w_in_head;
      end
    end else begin
      // Blocks indefinitely without an ack; the word stays in the FIFO.
      if (to_node_ack) begin
        r_tx_state    <= c_TX_IDLE;
        r_to_node_req <= 1'b0;
      end
    end
  end

  assign to_node_req  = r_to_node_req;
  assign to_node_data = r_to_node_data;

  // --------------------------------------------------------------------------
  // Outbound FIFO (node -> host)
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] r_out_mem [DEPTH];
  logic [c_AW:0]     r_out_wr;
  logic [c_AW:0]     r_out_rd;
  logic [c_AW:0]     w_out_count;
  logic              w_out_full;
  logic              w_out_empty;
  logic              w_out_pop_ok;
  logic              w_out_wr;

  logic [0:0]        r_rx_state;
  logic              r_fr_node_ack;

  assign w_out_count  = r_out_wr - r_out_rd;
  assign w_out_full   = (w_out_count == c_DEPTH_CNT);
  assign w_out_empty  = (r_out_wr == r_out_rd);
  assign w_out_pop_ok = pop && !w_out_empty;
  // Node words are never dropped: without room the node simply is not acked.
  // A host pop in the same cycle counts as room.
  assign w_out_wr     = (r_rx_state == c_RX_IDLE) && fr_node_req &&
                        (!w_out_full || w_out_pop_ok);

  // Outbound storage write.
  always_ff @(posedge clk) begin
    if (w_out_wr) begin
      r_out_mem[r_out_wr[c_AW-1:0]] <= fr_node_data;
    end
  end

  // Outbound pointer update; a pop while empty leaves everything unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wr <= '0;
      r_out_rd <= '0;
    end else if (clear) begin
      r_out_wr <= '0;
      r_out_rd <= '0;
    end else begin
      if (w_out_wr) begin
        r_out_wr <= r_out_wr + 1'b1;
      end
      if (w_out_pop_ok) begin
        r_out_rd <= r_out_rd + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RX handshake: one-cycle ack per accepted word, then back to IDLE.
  // --------------------------------------------------------------------------
  // RX FSM; a req still high during ACK is a node protocol error and is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state    <= c_RX_IDLE;
      r_fr_node_ack <= 1'b0;
    end else if (clear) begin
      r_rx_state    <= c_RX_IDLE;
      r_fr_node_ack <= 1'b0;
    end else if (r_rx_state == c_RX_IDLE) begin
      if (w_out_wr) begin
        r_rx_state    <= c_RX_ACK;
        r_fr_node_ack <= 1'b1;
      end
    end else begin
      r_rx_state    <= c_RX_IDLE;
      r_fr_node_ack <= 1'b0;
    end
  end

  assign fr_node_ack = r_fr_node_ack;

  // --------------------------------------------------------------------------
  // Sticky overflow: only a host push into a full inbound FIFO can set it.
  // --------------------------------------------------------------------------
  logic r_ovf;

  // Overflow flag, cleared only by reset or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
    end else if (w_in_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign full     = w_in_full;
  assign empty    = w_out_empty;
  assign ovf      = r_ovf;
  assign pop_data = w_out_empty ? '0 : r_out_mem[r_out_rd[c_AW-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_edge_stream.sv
// ============================================================================
// Module      : tb_edge_stream
// Description : Self-checking bench for edge_stream. Randomized words are
//               tracked in queue-based reference FIFOs; host and node sides
//               are driven from scenario tasks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_stream;

  localparam int WORD_W = 11;
  localparam int DEPTH  = 8;
  localparam int BUDGET = 20;

  typedef logic [WORD_W-1:0] word_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  clear;
  logic  push;
  word_t push_data;
  logic  full;
  logic  pop;
  word_t pop_data;
  logic  empty;
  logic  ovf;
  logic  to_node_req;
  word_t to_node_data;
  logic  to_node_ack;
  logic  fr_node_req;
  word_t fr_node_data;
  logic  fr_node_ack;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  edge_stream #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .push         (push),
    .push_data    (push_data),
    .full         (full),
    .pop          (pop),
    .pop_data     (pop_data),
    .empty        (empty),
    .ovf          (ovf),
    .to_node_req  (to_node_req),
    .to_node_data (to_node_data),
    .to_node_ack  (to_node_ack),
    .fr_node_req  (fr_node_req),
    .fr_node_data (fr_node_data),
    .fr_node_ack  (fr_node_ack)
  );

  function automatic word_t rand_word();
    int v;
    v = int'($urandom_range(1998)) - 999;
    return word_t'(v);
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Node-side receiver: wait for req, hold for wait_cycles, then ack once.
  // gap = cycles waited for req (-1 on timeout); stable = req/data held.
  task automatic node_take(input int wait_cycles, output word_t w,
                           output int gap, output bit stable);
    int n;
    n = 0;
    while (!to_node_req && n < BUDGET) begin
      tick();
      n++;
    end
    if (!to_node_req) begin
      gap = -1; w = '0; stable = 1'b0;
      return;
    end
    w = to_node_data;
    stable = 1'b1;
    repeat (wait_cycles) begin
      tick();
      if (!to_node_req || to_node_data !== w) stable = 1'b0;
    end
    to_node_ack = 1'b1;
    tick();
    to_node_ack = 1'b0;
    gap = n;
  endtask

  // Node-side sender: one word, one req cycle; reports the ack seen.
  task automatic node_send(input word_t w, output logic ack_seen);
    fr_node_req  = 1'b1;
    fr_node_data = w;
    tick();
    ack_seen = fr_node_ack;
    fr_node_req = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    word_t w [3];
    word_t x;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({full, empty, ovf, to_node_req, fr_node_ack} !== 5'b01000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 01000", {full, empty, ovf, to_node_req, fr_node_ack});
    end
    vectors++;
    if (pop_data !== '0 || to_node_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: pop_data %0d to_node_data %0d want 0 0", pop_data, to_node_data);
    end
    for (int i = 0; i < 3; i++) begin
      w[i] = rand_word();
      push = 1'b1; push_data = w[i];
      tick();
    end
    push = 1'b0;
    vectors++;
    if (to_node_req !== 1'b1 || to_node_data !== w[0]) begin
      miscompares++;
      $display("FAIL reset_pre_offer: req %b data %0d want 1 %0d", to_node_req, $signed(to_node_data), $signed(w[0]));
    end
    // Asynchronous reset mid-OFFER, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({full, empty, ovf, to_node_req} !== 4'b0100 || to_node_data !== '0) begin
      miscompares++;
      $display("FAIL reset_async: flags %b data %0d want 0100 0", {full, empty, ovf, to_node_req}, to_node_data);
    end
    tick();
    rst_n = 1'b1;
    x = rand_word();
    push = 1'b1; push_data = x;
    tick();
    push = 1'b0;
    vectors++;
    if (to_node_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_latency_1edge: req %b want 0", to_node_req);
    end
    tick();
    vectors++;
    if (to_node_req !== 1'b1 || to_node_data !== x) begin
      miscompares++;
      $display("FAIL reset_latency_2edge: req %b data %0d want 1 %0d", to_node_req, $signed(to_node_data), $signed(x));
    end
    to_node_ack = 1'b1;
    tick();
    to_node_ack = 1'b0;
    tick();
    tick();
    // The three pre-reset words must have been discarded.
    vectors++;
    if (to_node_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_discard: req %b want 0", to_node_req);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_inbound();
    word_t q[$];
    word_t w;
    int    gap;
    bit    stable;
    int    wc;
    do_clear();
    q.push_back(word_t'(5));
    q.push_back(word_t'(-7));
    q.push_back(word_t'(999));
    for (int i = 0; i < 4; i++) q.push_back(rand_word());
    foreach (q[i]) begin
      push = 1'b1; push_data = q[i];
      tick();
      if (to_node_req) begin
        vectors++;
        if (to_node_data !== q[0]) begin
          miscompares++;
          $display("FAIL inbound_offer_stable: data %0d want %0d", $signed(to_node_data), $signed(q[0]));
        end
      end
    end
    push = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wc = (i < 3) ? ((i % 2 == 0) ? 0 : 3) : int'($urandom_range(4));
      node_take(wc, w, gap, stable);
      vectors++;
      if (gap < 0 || w !== q[i] || !stable) begin
        miscompares++;
        $display("FAIL inbound_word%0d: got %0d gap %0d stable %b want %0d", i, $signed(w), gap, stable, $signed(q[i]));
      end
      vectors++;
      if (to_node_req !== 1'b0 || (i > 0 && gap != 1)) begin
        miscompares++;
        $display("FAIL inbound_req_gap%0d: req %b gap %0d want 0 1", i, to_node_req, gap);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_outbound();
    word_t q[$];
    logic  a;
    do_clear();
    q.push_back(word_t'(12));
    q.push_back(word_t'(-999));
    for (int i = 0; i < 4; i++) q.push_back(rand_word());
    foreach (q[i]) begin
      node_send(q[i], a);
      vectors++;
      if (a !== 1'b1 || fr_node_ack !== 1'b0 || empty !== 1'b0) begin
        miscompares++;
        $display("FAIL outbound_ack%0d: ack %b then %b empty %b want 1 0 0", i, a, fr_node_ack, empty);
      end
    end
    foreach (q[i]) begin
      vectors++;
      if (empty !== 1'b0 || pop_data !== q[i]) begin
        miscompares++;
        $display("FAIL outbound_pop%0d: empty %b data %0d want 0 %0d", i, empty, $signed(pop_data), $signed(q[i]));
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    vectors++;
    if (empty !== 1'b1 || pop_data !== '0) begin
      miscompares++;
      $display("FAIL outbound_empty: empty %b data %0d want 1 0", empty, pop_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_ovf();
    word_t q[$];
    word_t w;
    int    gap;
    bit    stable;
    do_clear();
    for (int k = 0; k < DEPTH + 1; k++) begin
      w = rand_word();
      if (q.size() < DEPTH) q.push_back(w);
      push = 1'b1; push_data = w;
      tick();
      vectors++;
      if (full !== (q.size() == DEPTH) || ovf !== (k == DEPTH)) begin
        miscompares++;
        $display("FAIL full_push%0d: full %b ovf %b want %b %b", k, full, ovf, q.size() == DEPTH, k == DEPTH);
      end
    end
    push = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      node_take(0, w, gap, stable);
      vectors++;
      if (gap < 0 || w !== q[i]) begin
        miscompares++;
        $display("FAIL full_drain%0d: got %0d gap %0d want %0d", i, $signed(w), gap, $signed(q[i]));
      end
    end
    tick();
    tick();
    vectors++;
    if (full !== 1'b0 || ovf !== 1'b1 || to_node_req !== 1'b0) begin
      miscompares++;
      $display("FAIL full_after_drain: full %b ovf %b req %b want 0 1 0", full, ovf, to_node_req);
    end
    do_clear();
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL full_clear_ovf: ovf %b want 0", ovf);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    word_t q[$];
    logic  a;
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back(rand_word());
      node_send(q[i], a);
    end
    fr_node_req  = 1'b1;
    fr_node_data = word_t'(42);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (fr_node_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stall%0d: ack %b want 0", i, fr_node_ack);
      end
    end
    vectors++;
    if (pop_data !== q[0]) begin
      miscompares++;
      $display("FAIL bp_head: data %0d want %0d", $signed(pop_data), $signed(q[0]));
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    vectors++;
    if (fr_node_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ack_after_pop: ack %b want 1", fr_node_ack);
    end
    fr_node_req = 1'b0;
    void'(q.pop_front());
    q.push_back(word_t'(42));
    tick();
    foreach (q[i]) begin
      vectors++;
      if (empty !== 1'b0 || pop_data !== q[i]) begin
        miscompares++;
        $display("FAIL bp_pop%0d: empty %b data %0d want 0 %0d", i, empty, $signed(pop_data), $signed(q[i]));
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_empty: empty %b want 1", empty);
    end
  endtask

  // --------------------------------------------------------------------------
  // Push and node-pop land in the same cycle, keeping occupancy constant.
  task automatic test_back_to_back(input int prefill, input int words);
    word_t q[$];
    word_t w;
    word_t nw;
    int    n;
    int    gap;
    bit    stable;
    logic  was_full;
    do_clear();
    for (int i = 0; i < prefill; i++) begin
      q.push_back(rand_word());
      push = 1'b1; push_data = q[i];
      tick();
    end
    push = 1'b0;
    for (int i = 0; i < words; i++) begin
      n = 0;
      while (!to_node_req && n < BUDGET) begin
        tick();
        n++;
      end
      w  = q.pop_front();
      vectors++;
      if (to_node_req !== 1'b1 || to_node_data !== w) begin
        miscompares++;
        $display("FAIL b2b%0d_word%0d: req %b data %0d want 1 %0d", prefill, i, to_node_req, $signed(to_node_data), $signed(w));
      end
      was_full = full;
      nw = rand_word();
      q.push_back(nw);
      push = 1'b1; push_data = nw; to_node_ack = 1'b1;
      tick();
      push = 1'b0; to_node_ack = 1'b0;
      vectors++;
      if (full !== was_full || full !== (prefill == DEPTH) || ovf !== 1'b0 || to_node_req !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b%0d_occupancy%0d: full %b ovf %b req %b want %b 0 0", prefill, i, full, ovf, to_node_req, prefill == DEPTH);
      end
    end
    for (int i = 0; i < prefill; i++) begin
      node_take(0, w, gap, stable);
      vectors++;
      if (gap < 0 || w !== q[i]) begin
        miscompares++;
        $display("FAIL b2b%0d_drain%0d: got %0d gap %0d want %0d", prefill, i, $signed(w), gap, $signed(q[i]));
      end
    end
    tick();
    tick();
    vectors++;
    if (to_node_req !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b%0d_leftover: req %b want 0", prefill, to_node_req);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; clear = 1'b0; push = 1'b0; push_data = '0; pop = 1'b0;
    to_node_ack = 1'b0; fr_node_req = 1'b0; fr_node_data = '0;
    test_reset();
    test_inbound();
    test_outbound();
    test_full_ovf();
    test_backpressure();
    test_back_to_back(4, 20);
    test_back_to_back(DEPTH, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
